depadder: RTL and testbench

- Receive-side inverse of the SHA-3 padder in the low-throughput core.
- Accepts padded rate blocks of BLOCK_WORDS 32-bit words, buffers each block and strips the Keccak pad (0x01, 0x00*, 0x80, or a single 0x81).
- Emits the original message words using the same last-word convention the padder consumes: is_last plus byte_num.
- Used for loopback verification of the padder and for parsing host-supplied padded streams.

---
 rtl/depadder.sv | 146 ++++++++++++++
 tb/tb_depadder.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/depadder.sv
// Receive-side inverse of the SHA-3 padder: buffers one rate block, strips the
// Keccak pad, and re-emits the message words with is_last/byte_num framing.
module depadder #(
  parameter int BLOCK_WORDS = 18
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] in,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  output logic [31:0] out,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic [1:0]  byte_num,
  output logic        pad_error
);

  localparam int WW = $clog2(BLOCK_WORDS);
  localparam int PW = WW + 2;
  localparam logic [WW-1:0] LAST_W = WW'(BLOCK_WORDS - 1);
  localparam logic [PW-1:0] LAST_P = PW'(4 * BLOCK_WORDS - 1);

  typedef enum logic [1:0] {FILL, SCAN, EMIT} state_t;

  state_t        state, state_next;
  logic [31:0]   buffer [BLOCK_WORDS];
  logic [WW-1:0] wcnt;
  logic [WW-1:0] k;
  logic [WW-1:0] last_k;
  logic [PW-1:0] p;
  logic [PW-1:0] m;
  logic          final_blk;
  logic [31:0]   scan_word;
  logic [7:0]    scan_byte;
  logic          scan_hit;
  logic          scan_err;
  logic [31:0]   keep_mask;

  // Byte p of the block: word p/4, byte 0 of each word in the top lane.
  always_comb begin
    scan_word = buffer[p[PW-1:2]];
    case (p[1:0])
      2'd0:    scan_byte = scan_word[31:24];
      2'd1:    scan_byte = scan_word[23:16];
      2'd2:    scan_byte = scan_word[15:8];
      default: scan_byte = scan_word[7:0];
    endcase
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    scan_hit   = 1'b0;
    scan_err   = 1'b0;
    unique case (state)
      FILL: begin
        in_ready = 1'b1;
        if (in_valid && wcnt == LAST_W) state_next = in_last ? SCAN : EMIT;
      end
      SCAN: begin
        if (p == LAST_P) begin
          if (scan_byte == 8'h81)      scan_hit = 1'b1;
          else if (scan_byte != 8'h80) scan_err = 1'b1;
        end else if (scan_byte == 8'h01) begin
          scan_hit = 1'b1;
        end else if (scan_byte != 8'h00 || p == '0) begin
          scan_err = 1'b1;
        end
        if (scan_hit)      state_next = EMIT;
        else if (scan_err) state_next = FILL;
      end
      EMIT: begin
        out_valid = 1'b1;
        if (out_ready && k == last_k) state_next = FILL;
      end
      default: state_next = FILL;
    endcase
  end

  // Non-final blocks always emit the full block; final blocks stop at word M/4.
  assign last_k   = final_blk ? m[PW-1:2] : LAST_W;
  assign out_last = (state == EMIT) && final_blk && (k == m[PW-1:2]);
  assign byte_num = out_last ? m[1:0] : 2'd0;

  always_comb begin
    case (m[1:0])
      2'd0:    keep_mask = 32'h0000_0000;
      2'd1:    keep_mask = 32'hFF00_0000;
      2'd2:    keep_mask = 32'hFFFF_0000;
      default: keep_mask = 32'hFFFF_FF00;
    endcase
  end

  assign out = out_valid ? (buffer[k] & (out_last ? keep_mask : 32'hFFFF_FFFF)) : 32'h0;

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) state <= FILL;
    else       state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wcnt      <= '0;
      k         <= '0;
      p         <= '0;
      m         <= '0;
      final_blk <= 1'b0;
      pad_error <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          if (in_valid) begin
            if (wcnt == LAST_W) begin
              wcnt      <= '0;
              p         <= LAST_P;
              final_blk <= in_last;
              k         <= '0;
            end else begin
              wcnt <= wcnt + 1'b1;
            end
          end
        end
        SCAN: begin
          if (scan_hit)      m         <= p;
          else if (scan_err) pad_error <= 1'b1;
          else               p         <= p - 1'b1;
        end
        EMIT: begin
          if (out_ready) k <= (k == last_k) ? '0 : k + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // NOTE: the block buffer is deliberately not reset; only words written in FILL are ever read.
  always_ff @(posedge clk) begin
    if (state == FILL && in_valid) buffer[wcnt] <= in;
  end

endmodule

// File: tb/tb_depadder.sv
// Self-checking bench for depadder: directed vector table, hand-written
// backpressure/reset sequences, and randomized blocks against a byte-level model.
module tb_depadder;

  localparam int BW = 18;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] in;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic [31:0] out;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic [1:0]  byte_num;
  logic        pad_error;

  always #5 clk = ~clk;

  depadder #(.BLOCK_WORDS(BW)) dut (
    .clk       (clk),
    .reset     (reset),
    .in        (in),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out       (out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .byte_num  (byte_num),
    .pad_error (pad_error)
  );

  typedef logic [BW-1:0][31:0] blk_t;

  typedef struct packed {
    blk_t        w;
    logic        last;
    logic [7:0]  n;
    logic [31:0] tail;
    logic [1:0]  bnum;
    logic        err;
    logic [7:0]  lat;   // 255 = latency not checked
  } vec_t;

  int          tests  = 0;
  int          failed = 0;
  logic [31:0] exp_w [BW];
  logic        exp_l [BW];
  logic [1:0]  exp_b [BW];
  int          exp_n;
  bit          exp_err;
  bit          err_sticky;
  int          got_n;
  int          got_lat;
  logic [31:0] got_tail;
  logic [1:0]  got_b;
  vec_t        tbl [10];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [7:0] byte_at(input blk_t w, input int j);
    return w[j/4][31-8*(j%4) -: 8];
  endfunction

  // Strip the pad from the byte view of the block and list expected output words.
  function automatic void model(input blk_t w, input logic last);
    int m;
    int j;
    logic [31:0] d;
    exp_err = 1'b0;
    exp_n   = 0;
    for (int i = 0; i < BW; i++) begin
      exp_w[i] = w[i];
      exp_l[i] = 1'b0;
      exp_b[i] = 2'd0;
    end
    if (!last) begin
      exp_n = BW;
      return;
    end
    m = -1;
    if (byte_at(w, 4*BW-1) == 8'h81) begin
      m = 4*BW-1;
    end else if (byte_at(w, 4*BW-1) == 8'h80) begin
      j = 4*BW-2;
      while (j >= 0 && byte_at(w, j) == 8'h00) j--;
      if (j >= 0 && byte_at(w, j) == 8'h01) m = j;
    end
    if (m < 0) begin
      exp_err = 1'b1;
      return;
    end
    exp_n = m/4 + 1;
    d = 32'h0;
    for (int q = 0; q < m % 4; q++) d[31-8*q -: 8] = byte_at(w, 4*(exp_n-1) + q);
    exp_w[exp_n-1] = d;
    exp_l[exp_n-1] = 1'b1;
    exp_b[exp_n-1] = 2'(m % 4);
  endfunction

  task automatic send_block(input blk_t w, input logic last, input bit gaps);
    int t;
    for (int i = 0; i < BW; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (gaps) while ($urandom_range(0, 3) == 0) @(negedge clk);
      t = 0;
      while (!in_ready && t < 200) begin
        @(negedge clk);
        t++;
      end
      if (!in_ready) check("in_ready_timeout", 0, 1);
      in       = w[i];
      in_valid = 1'b1;
      in_last  = (i == BW-1) ? last : 1'($urandom);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // mode 0: always ready, 1: random ready, 2: stall 5 cycles at word 4
  task automatic collect(input int mode);
    int idx   = 0;
    int cyc   = 0;
    int stall = 0;
    got_lat = -1;
    while (idx < exp_n && cyc < 600) begin
      if (mode == 0)      out_ready = 1'b1;
      else if (mode == 1) out_ready = ($urandom_range(0, 2) != 0);
      else begin
        out_ready = !(idx == 4 && stall < 5);
        if (!out_ready && out_valid) stall++;
      end
      if (out_valid) begin
        if (got_lat < 0) got_lat = cyc;
        check($sformatf("word%0d", idx), {out_last, byte_num, out},
              {exp_l[idx], exp_b[idx], exp_w[idx]});
        if (out_ready) begin
          got_tail = out;
          got_b    = byte_num;
          idx++;
        end
      end
      @(negedge clk);
      cyc++;
    end
    got_n = idx;
    if (idx < exp_n) check("emit_timeout", idx, exp_n);
    check("post_emit_out_valid", out_valid, 0);
    check("post_emit_in_ready", in_ready, 1);
  endtask

  task automatic expect_error();
    int cyc = 0;
    bit saw = 1'b0;
    while (!in_ready && cyc < 4*BW + 10) begin
      if (out_valid) saw = 1'b1;
      @(negedge clk);
      cyc++;
    end
    check("err_no_output", saw, 0);
    check("err_back_to_fill", in_ready, 1);
  endtask

  task automatic run_block(input blk_t w, input logic last, input int mode);
    got_n = 0;
    model(w, last);
    send_block(w, last, mode == 1);
    if (exp_err) expect_error();
    else         collect(mode);
    err_sticky |= exp_err;
    check("pad_error", pad_error, err_sticky);
  endtask

  function automatic blk_t rand_blk();
    blk_t b;
    for (int i = 0; i < BW; i++) b[i] = $urandom;
    return b;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    blk_t b;
    int   cnt;
    int   t;
    int   len;

    // Directed vectors
    b = '0; b[0] = 32'h90AB0100; b[BW-1] = 32'h0000_0080;
    tbl[0] = '{w: b, last: 1'b1, n: 8'd1, tail: 32'h90AB0000, bnum: 2'd2, err: 1'b0, lat: 8'd70};
    for (int i = 0; i < BW; i++) b[i] = 32'hCCCCCCCC;
    b[BW-1] = 32'hCCCCCC81;
    tbl[1] = '{w: b, last: 1'b1, n: 8'd18, tail: 32'hCCCCCC00, bnum: 2'd3, err: 1'b0, lat: 8'd1};
    b = '0; b[0] = 32'h0100_0000; b[BW-1] = 32'h0000_0080;
    tbl[2] = '{w: b, last: 1'b1, n: 8'd1, tail: 32'h0, bnum: 2'd0, err: 1'b0, lat: 8'd72};
    for (int i = 0; i < BW; i++) b[i] = 32'(i);
    tbl[3] = '{w: b, last: 1'b0, n: 8'd18, tail: 32'h11, bnum: 2'd0, err: 1'b0, lat: 8'd0};
    tbl[4] = tbl[2];
    b = '0;
    tbl[5] = '{w: b, last: 1'b1, n: 8'd0, tail: 32'h0, bnum: 2'd0, err: 1'b1, lat: 8'd255};
    b = '0; b[0] = 32'h0200_0000; b[BW-1] = 32'h0000_0080;
    tbl[6] = '{w: b, last: 1'b1, n: 8'd0, tail: 32'h0, bnum: 2'd0, err: 1'b1, lat: 8'd255};
    tbl[7] = tbl[0];
    for (int i = 0; i < BW; i++) b[i] = 32'hAAAAAAAA;
    b[BW-1] = 32'h0100_0080;
    tbl[8] = '{w: b, last: 1'b1, n: 8'd18, tail: 32'h0, bnum: 2'd0, err: 1'b0, lat: 8'd4};
    b = '0; b[BW-1] = 32'h0000_0001;
    tbl[9] = '{w: b, last: 1'b1, n: 8'd0, tail: 32'h0, bnum: 2'd0, err: 1'b1, lat: 8'd255};

    reset      = 1'b1;
    in         = 32'h0;
    in_valid   = 1'b0;
    in_last    = 1'b0;
    out_ready  = 1'b0;
    err_sticky = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("reset_in_ready", in_ready, 1);
    check("reset_outputs", {out_valid, out_last, byte_num, out}, 0);
    check("reset_pad_error", pad_error, 0);

    for (int v = 0; v < 10; v++) begin
      run_block(tbl[v].w, tbl[v].last, 0);
      if (!tbl[v].err) begin
        check($sformatf("vec%0d_count", v), got_n, tbl[v].n);
        check($sformatf("vec%0d_tail", v), {got_b, got_tail}, {tbl[v].bnum, tbl[v].tail});
        if (tbl[v].lat != 8'd255) check($sformatf("vec%0d_latency", v), got_lat, tbl[v].lat);
      end
    end

    // Backpressure: out_ready low for 5 cycles while word 4 is presented
    run_block(rand_blk(), 1'b0, 2);

    // Reset mid-EMIT with pad_error set
    run_block(tbl[5].w, 1'b1, 0);
    b = rand_blk();
    model(b, 1'b0);
    send_block(b, 1'b0, 1'b0);
    out_ready = 1'b1;
    cnt = 0;
    t   = 0;
    while (cnt < 3 && t < 100) begin
      if (out_valid) begin
        check($sformatf("pre_reset_word%0d", cnt), out, exp_w[cnt]);
        cnt++;
      end
      @(negedge clk);
      t++;
    end
    reset = 1'b1;
    @(negedge clk);
    reset      = 1'b0;
    err_sticky = 1'b0;
    check("emit_reset_out_valid", out_valid, 0);
    check("emit_reset_pad_error", pad_error, 0);
    check("emit_reset_in_ready", in_ready, 1);
    cnt = 0;
    repeat (10) begin
      if (out_valid) cnt++;
      @(negedge clk);
    end
    check("emit_reset_no_output", cnt, 0);

    // Reset mid-FILL abandons the partial block
    b = rand_blk();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in       = b[i];
      in_valid = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    reset    = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    run_block(tbl[1].w, 1'b1, 0);
    check("fill_reset_count", got_n, 18);

    // Randomized blocks: non-final, well-padded final, and arbitrary final
    for (int r = 0; r < 40; r++) begin
      b = rand_blk();
      case ($urandom_range(0, 2))
        0: run_block(b, 1'b0, 1);
        1: begin
          len = $urandom_range(0, 4*BW-1);
          if (len == 4*BW-1) begin
            b[BW-1][7:0] = 8'h81;
          end else begin
            b[len/4][31-8*(len%4) -: 8] = 8'h01;
            for (int j = len + 1; j < 4*BW-1; j++) b[j/4][31-8*(j%4) -: 8] = 8'h00;
            b[BW-1][7:0] = 8'h80;
          end
          run_block(b, 1'b1, 1);
        end
        default: run_block(b, 1'b1, 1);
      endcase
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
